// File: rtl/manchester_rx_framer_pkg.sv
// Shared definitions for the Manchester byte link: sync word, line code and
// receive framer state encoding.
package manchester_pkg;

   localparam logic [23:0] SYNC_PATTERN = 24'hAAAAD5;
   localparam logic [1:0]  LC_ONE       = 2'b10;
   localparam logic [1:0]  LC_ZERO      = 2'b01;
   localparam int          SR_W         = 27;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_HUNT     = 2'd1,
      ST_PAYLOAD  = 2'd2
   } rx_state_e;

   function automatic logic pair_bad(input logic [1:0] pair);
      return (pair != LC_ONE) && (pair != LC_ZERO);
   endfunction

   function automatic logic pair_bit(input logic [1:0] pair);
      return pair == LC_ONE;
   endfunction

endpackage

// File: rtl/manchester_rx_framer_if.sv
// Receive-side bundle: raw line words in, decoded bytes and framing status out.
interface manchester_rx_framer_if;

   logic [7:0] rx_word;
   logic       rx_valid;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       frame_start;
   logic       frame_end;
   logic       frame_err;
   logic       locked;
   logic       phase;

   modport master (
      output rx_word, rx_valid,
      input  byte_data, byte_valid, frame_start, frame_end, frame_err, locked, phase
   );

   modport slave (
      input  rx_word, rx_valid,
      output byte_data, byte_valid, frame_start, frame_end, frame_err, locked, phase
   );

endinterface

// File: rtl/manchester_rx_framer_decoder.sv
// Splits one 8-bit line word into four Manchester pairs for a fixed pair phase
// and returns the data bits (oldest in bit 3) plus a code-violation flag.
module manchester_decoder
   import manchester_pkg::*;
(
   input  logic [7:0] word,
   input  logic       prev_bit,
   input  logic       phase_sel,
   output logic [3:0] data,
   output logic       err
);

   logic [8:0] line;
   logic [1:0] pairs [4];

   assign line = {prev_bit, word};

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      data = '0;
      err  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pairs[i]  = phase_sel ? line[8-2*i -: 2] : line[7-2*i -: 2];
         data[3-i] = pair_bit(pairs[i]);
         err       = err | pair_bad(pairs[i]);
      end
   end

endmodule

// File: rtl/manchester_rx_framer.sv
// Manchester receive framer: locks pair phase, hunts for AA AA D5 and emits
// PAYLOAD_LEN decoded bytes per frame with start/end markers.
module manchester_rx_framer
   import manchester_pkg::*;
#(
   parameter int PAYLOAD_LEN      = 4,
   parameter int PHASE_LOCK_WORDS = 4
) (
   input  logic                   clk108,
   input  logic                   aresetn,
   manchester_rx_framer_if.slave  bus
);

   localparam logic [3:0] LOCK_CNT = 4'(PHASE_LOCK_WORDS);
   localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

   rx_state_e       state;
   logic [SR_W-1:0] shreg;
   logic [SR_W-1:0] sr_next;
   logic            prev_w0;
   logic [3:0]      good0, good1, good0_next, good1_next;
   logic [2:0]      bit_cnt;
   logic [7:0]      byte_idx;

   logic [7:0]      byte_data_q;
   logic            byte_valid_q, frame_start_q, frame_end_q, frame_err_q;
   logic            locked_q, phase_q;

   logic [3:0]      dec0_data, dec1_data, act_data;
   logic            dec0_err, dec1_err, act_err, act_phase;
   logic            sync_hit;
   logic [1:0]      sync_k;
   logic [3:0]      bits_total;
   logic            byte_done;
   logic [7:0]      byte_val;

   manchester_decoder u_dec0 (
      .word     (bus.rx_word),
      .prev_bit (prev_w0),
      .phase_sel(1'b0),
      .data     (dec0_data),
      .err      (dec0_err)
   );

   manchester_decoder u_dec1 (
      .word     (bus.rx_word),
      .prev_bit (prev_w0),
      .phase_sel(1'b1),
      .data     (dec1_data),
      .err      (dec1_err)
   );

   // While unlocked, follow whichever phase has the longer clean run (phase 0 on tie).
   assign act_phase = (state == ST_UNLOCKED) ? (good1 > good0) : phase_q;
   assign act_data  = act_phase ? dec1_data : dec0_data;
   assign act_err   = act_phase ? dec1_err  : dec0_err;
   assign sr_next   = {shreg[SR_W-5:0], act_data};

   assign good0_next = dec0_err ? 4'd0 : (good0 == LOCK_CNT) ? good0 : good0 + 4'd1;
   assign good1_next = dec1_err ? 4'd0 : (good1 == LOCK_CNT) ? good1 : good1 + 4'd1;

   // Pending payload bits are the newest bit_cnt bits of the shift register.
   assign bits_total = {1'b0, bit_cnt} + 4'd4;
   assign byte_done  = bits_total[3];
   assign byte_val   = 8'(sr_next >> (bit_cnt - 3'd4));

   always_comb begin
      sync_hit = 1'b0;
      sync_k   = '0;
      for (int k = 0; k < 4; k++) begin
         if (sr_next[k +: 24] == SYNC_PATTERN) begin
            sync_hit = 1'b1;
            sync_k   = 2'(k);
         end
      end
   end

   // NOTE: all state here is sequential, so every assignment is non-blocking.
   always_ff @(posedge clk108 or negedge aresetn) begin
      if (!aresetn) begin
         state         <= ST_UNLOCKED;
         shreg         <= '0;
         prev_w0       <= 1'b0;
         good0         <= '0;
         good1         <= '0;
         bit_cnt       <= '0;
         byte_idx      <= '0;
         byte_data_q   <= '0;
         byte_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         locked_q      <= 1'b0;
         phase_q       <= 1'b0;
      end else begin
         byte_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         if (bus.rx_valid) begin
            prev_w0 <= bus.rx_word[0];
            shreg   <= sr_next;
            good0   <= good0_next;
            good1   <= good1_next;
            case (state)
               ST_UNLOCKED: begin
                  if (good0_next == LOCK_CNT) begin
                     locked_q <= 1'b1;
                     phase_q  <= 1'b0;
                     state    <= ST_HUNT;
                  end else if (good1_next == LOCK_CNT) begin
                     locked_q <= 1'b1;
                     phase_q  <= 1'b1;
                     state    <= ST_HUNT;
                  end
               end
               ST_HUNT: begin
                  if (act_err) begin
                     state    <= ST_UNLOCKED;
                     locked_q <= 1'b0;
                     phase_q  <= 1'b0;
                     good0    <= '0;
                     good1    <= '0;
                  end else if (sync_hit) begin
                     state    <= ST_PAYLOAD;
                     bit_cnt  <= {1'b0, sync_k};
                     byte_idx <= '0;
                  end
               end
               ST_PAYLOAD: begin
                  if (act_err) begin
                     frame_err_q <= 1'b1;
                     state       <= ST_UNLOCKED;
                     locked_q    <= 1'b0;
                     phase_q     <= 1'b0;
                     good0       <= '0;
                     good1       <= '0;
                  end else begin
                     bit_cnt <= bits_total[2:0];
                     if (byte_done) begin
                        byte_data_q   <= byte_val;
                        byte_valid_q  <= 1'b1;
                        frame_start_q <= (byte_idx == 8'd0);
                        frame_end_q   <= (byte_idx == LAST_IDX);
                        if (byte_idx == LAST_IDX) state <= ST_HUNT;
                        else byte_idx <= byte_idx + 8'd1;
                     end
                  end
               end
               default: state <= ST_UNLOCKED;
            endcase
         end
      end
   end

   assign bus.byte_data   = byte_data_q;
   assign bus.byte_valid  = byte_valid_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_end   = frame_end_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.locked      = locked_q;
   assign bus.phase       = phase_q;

endmodule

// File: doc/manchester_rx_framer.md
Name: manchester_rx_framer

Overview:
- Receive side of the Manchester byte link: takes raw line bits from an upstream 1:8 deserializer, recovers Manchester pair phase, hunts for the sync pattern AA AA D5, and emits decoded payload bytes with frame markers.
- Sits in the clk108 domain directly behind the deserializer.
- Mirrors the transmitter's framing:
  - Line code is data 1 -> "10", data 0 -> "01", MSB first.
  - Frame is preamble AA, AA, then D5, then PAYLOAD_LEN bytes.

Parameters:
- PAYLOAD_LEN, 4, payload bytes per frame after D5 (1..255).
- PHASE_LOCK_WORDS, 4, consecutive error-free input words needed to lock a pair phase (1..15).

Ports:
- clk108  input  1  system clock.
- aresetn  input  1  asynchronous, active-low reset.
- rx_word  input  8  raw line bits; bit7 was transmitted first.
- rx_valid  input  1  rx_word is valid this cycle; gaps allowed.
- byte_data  output  8  decoded payload byte.
- byte_valid  output  1  one-cycle strobe, byte_data valid.
- frame_start  output  1  with byte_valid, on the first payload byte.
- frame_end  output  1  with byte_valid, on the last payload byte.
- frame_err  output  1  one-cycle pulse, frame aborted by a code error.
- locked  output  1  pair phase locked.
- phase  output  1  locked phase (0: pairs are bits 7:6,5:4,3:2,1:0; 1: pairs straddle word boundary).

Behaviour:
- Clock and reset: reset aresetn, asynchronous, active-low; clock clk108.
- Reset values: all outputs 0; state UNLOCKED; all counters and shift registers cleared.
- All logic advances only on cycles with rx_valid=1. With rx_valid=0, state holds and strobes are 0.
- Pair decode, per word, both phases in parallel:
  - Phase 0 pairs: (w7,w6), (w5,w4), (w3,w2), (w1,w0).
  - Phase 1 pairs: (prev_w0,w7), (w6,w5), (w4,w3), (w2,w1).
  - prev_w0 is a register; its reset value is 0.
  - Each phase yields 4 data bits, oldest first, plus err = any pair 00 or 11.
- Data shift register: 27 bits. Each valid word shifts in the 4 decoded bits of the active phase:
  - in UNLOCKED, the phase with the higher good-word count; phase 0 on tie.
  - otherwise, the locked phase.
- Per-phase good-word counters:
  - Saturate at PHASE_LOCK_WORDS.
  - Clear on a word with err in that phase.
- State UNLOCKED:
  - When a phase counter reaches PHASE_LOCK_WORDS, set locked=1 and phase to that phase; go to HUNT.
  - If both reach it in the same word, phase 0 wins.
- State HUNT:
  - Any err in the locked phase -> UNLOCKED, locked=0, counters cleared. No frame_err.
  - Otherwise, test the 4 alignments k=0..3: sync AA_AA_D5 ending k bits before the newest bit.
  - On match (largest k wins), the k newest bits seed the byte assembler; bit count = k.
  - Go to PAYLOAD with byte index 0.
  - Sync is never tested in UNLOCKED or PAYLOAD.
- State PAYLOAD:
  - Bits accumulate MSB first. When 8 bits complete, register byte_data and pulse byte_valid in the cycle after the completing word.
    - Latency is 1 clk108 from that word's rx_valid.
    - At most one byte completes per word.
  - frame_start is asserted on index 0; frame_end on index PAYLOAD_LEN-1, after which the block returns to HUNT.
    - When PAYLOAD_LEN=1, frame_start and frame_end are both asserted.
    - Leftover bits of that word are discarded.
  - Any err in the locked phase:
    - Pulse frame_err; suppress any byte completing in that word.
    - Go to UNLOCKED, locked=0, counters cleared.
- Reset mid-operation: immediate return to reset values; no partial byte or strobe is emitted.

Decomposition:
- Package manchester_pkg holds:
  - SYNC_PATTERN = 24'hAAAAD5;
  - state encoding UNLOCKED/HUNT/PAYLOAD;
  - line-code constants LC_ONE=2'b10 and LC_ZERO=2'b01 (shared with the encoder).
- One combinational sub-module, manchester_decoder:
  - Inputs: 8-bit word, prev bit, phase select.
  - Outputs: 4 data bits and error flag.
  - Instantiated twice, one per phase.

Test Plan:
- Clean phase-0 stream of repeating frames AA AA D5 AA BB CC DD (PAYLOAD_LEN=4):
  - locked=1, phase=0 after word 4.
  - bytes AA, BB, CC, DD, with frame_start on AA and frame_end on DD, on every frame, first frame included.
  - No frame_err.
- Same stream delayed by 1 line bit -> phase=1 lock; identical byte sequence.
- Stream prefixed by k=1,2,3 extra data bits ("01" pairs):
  - correct byte alignment for each k;
  - first payload byte is AA.
- Force pair "11" inside the CC byte of frame 2:
  - frame_err pulse; no CC/DD or frame_end for that frame;
  - locked drops, relocks, and the next frame decodes AA BB CC DD.
- rx_valid toggled 1/0 randomly on the clean stream -> identical byte/flag sequence; no strobe while rx_valid=0.
- aresetn asserted mid-payload after BB:
  - all outputs 0 at once;
  - after release, the first complete frame decodes correctly.
